// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_schedule_ctrl : AES-128 key capture and round-key expansion, one word
// per cycle through a shared S-box, with combinational round-key read-out.
// Rev 1.0
// ---------------------------------------------------------------------------
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_start,
  input  logic [31:0] key_word_in,
  input  logic        sbox_gnt,
  input  logic [31:0] sbox_out,
  output logic        sbox_req,
  output logic [31:0] sbox_in,
  output logic        key_expand_done,
  input  logic [3:0]  rk_round,
  input  logic [1:0]  rk_col,
  output logic [31:0] rk_word,
  output logic [1:0]  dbg_state,
  output logic [5:0]  dbg_word_idx
);

  localparam int         c_nw        = 4 * (NUM_ROUNDS + 1);
  localparam logic [5:0] c_last_idx  = 6'(c_nw - 1);
  localparam logic [3:0] c_max_round = 4'(NUM_ROUNDS);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_load   = 2'd1;
  localparam logic [1:0] c_st_expand = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [5:0]  r_idx;
  logic [7:0]  r_rcon;
  logic        r_done;
  logic [31:0] r_sched [c_nw];

  logic        w_wr_en;
  logic        w_advance;
  logic [31:0] w_wr_data;
  logic [31:0] w_prev4;
  logic [31:0] w_prev1;
  logic        w_sub_slot;
  logic [5:0]  w_rd_idx;

  assign w_prev4    = r_sched[r_idx - 6'd4];
  assign w_prev1    = r_sched[r_idx - 6'd1];
  assign w_sub_slot = (r_state == c_st_expand) && (r_idx[1:0] == 2'b00);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a fresh key_start overrides everything, even the final write
  always_comb begin
    w_state_nxt = r_state;
    if (key_start) begin
      w_state_nxt = c_st_load;
    end else begin
      case (r_state)
        c_st_load:   if (r_idx[1:0] == 2'd3) w_state_nxt = c_st_expand;
        c_st_expand: if (w_advance && (r_idx == c_last_idx)) w_state_nxt = c_st_done;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    sbox_req  = 1'b0;
    sbox_in   = '0;
    dbg_state = r_state;
    if (w_sub_slot) begin
      sbox_req = 1'b1;
      sbox_in  = {w_prev1[23:0], w_prev1[31:24]};
    end
  end

  // Word generation; the SubWord slot stalls until the shared S-box is granted
  always_comb begin
    w_wr_en   = 1'b0;
    w_advance = 1'b0;
    w_wr_data = '0;
    if (!key_start) begin
      case (r_state)
        c_st_load: begin
          w_wr_en   = 1'b1;
          w_advance = 1'b1;
          w_wr_data = key_word_in;
        end
        c_st_expand: begin
          if (r_idx[1:0] != 2'b00) begin
            w_wr_en   = 1'b1;
            w_advance = 1'b1;
            w_wr_data = w_prev4 ^ w_prev1;
          end else if (sbox_gnt) begin
            w_wr_en   = 1'b1;
            w_advance = 1'b1;
            w_wr_data = w_prev4 ^ sbox_out ^ {r_rcon, 24'h0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= '0;
      r_rcon <= 8'h01;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == c_st_done);
      if (key_start) begin
        r_idx  <= '0;
        r_rcon <= 8'h01;
      end else begin
        // Index saturates on the last word so it reads NW-1 while done
        if (w_advance && (r_idx != c_last_idx)) r_idx <= r_idx + 6'd1;
        if (w_sub_slot && sbox_gnt)
          r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < c_nw; k++) r_sched[k] <= '0;
    end else if (w_wr_en) begin
      r_sched[r_idx] <= w_wr_data;
    end
  end

  assign key_expand_done = r_done;
  assign dbg_word_idx    = r_idx;

  // {round, col} is exactly 4*round+col
  assign w_rd_idx = {rk_round, rk_col};
  assign rk_word  = (rk_round > c_max_round) ? '0 : r_sched[w_rd_idx];

endmodule
`default_nettype wire
